// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and the round-constant lookup
// used by the decryption key schedule.
package aes_pkg;

   localparam int AES_ROUNDS = 10;
   localparam int KEY_WORDS  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_READY  = 2'd2
   } state_e;

   // Rcon byte for a round number; rounds outside 1..10 contribute nothing.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] value;
      case (round)
         4'd1:    value = 8'h01;
         4'd2:    value = 8'h02;
         4'd3:    value = 8'h04;
         4'd4:    value = 8'h08;
         4'd5:    value = 8'h10;
         4'd6:    value = 8'h20;
         4'd7:    value = 8'h40;
         4'd8:    value = 8'h80;
         4'd9:    value = 8'h1B;
         4'd10:   value = 8'h36;
         default: value = 8'h00;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/key_generator_dec_if.sv
// Handshake and key bus between the decryption FSM (master) and the
// reverse key schedule (slave).
interface key_generator_dec_if #(
   parameter int BLOCK_LENGTH = 128
);
   logic                    start;
   logic [BLOCK_LENGTH-1:0] key;
   logic                    en;
   logic                    rewind;
   logic [BLOCK_LENGTH-1:0] current_key;
   logic [3:0]              round_idx;
   logic                    key_valid;
   logic                    busy;
   logic                    done;

   modport master (
      output start, key, en, rewind,
      input  current_key, round_idx, key_valid, busy, done
   );

   modport slave (
      input  start, key, en, rewind,
      output current_key, round_idx, key_valid, busy, done
   );
endinterface

// File: rtl/key_generator_dec_g_function.sv
// AES key-schedule g function: RotWord, SubWord, then Rcon folded into the
// most significant byte.
module g_function
   import aes_pkg::*;
(
   input  logic [31:0] word_3,
   input  logic [3:0]  round_number,
   output logic [31:0] word_3_substituted
);

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] subByte(input logic [7:0] b);
      return SBOX[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   logic [31:0] rotated;

   assign rotated = {word_3[23:0], word_3[31:24]};

   assign word_3_substituted = {
      subByte(rotated[31:24]) ^ rcon(round_number),
      subByte(rotated[23:16]),
      subByte(rotated[15:8]),
      subByte(rotated[7:0])
   };

endmodule

// File: rtl/key_generator_dec.sv
// AES-128 decryption key schedule: expands K0 forward to K10, then hands out
// round keys K10..K0 one per advance, with a K10 cache for key reuse.
module key_generator_dec
   import aes_pkg::*;
#(
   parameter int BLOCK_LENGTH = 128
) (
   input logic                clk,
   input logic                rst,
   key_generator_dec_if.slave kif
);

   localparam int         WORD_W     = BLOCK_LENGTH / KEY_WORDS;
   localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS);

   state_e                  state_q, state_d;
   logic [BLOCK_LENGTH-1:0] work_q, work_d;
   logic [BLOCK_LENGTH-1:0] k10_cache_q, k10_cache_d;
   logic [BLOCK_LENGTH-1:0] current_key_q, current_key_d;
   logic [3:0]              rcnt_q, rcnt_d;
   logic [3:0]              round_idx_q, round_idx_d;
   logic                    cache_valid_q, cache_valid_d;
   logic                    key_valid_q, key_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic [WORD_W-1:0] fw0, fw1, fw2, fw3, fwdG, fn0, fn1, fn2, fn3;
   logic [WORD_W-1:0] cw0, cw1, cw2, cw3, invG, iw0, iw1, iw2, iw3;
   logic [BLOCK_LENGTH-1:0] fwdKey, invKey;

   // Forward step K[i] -> K[i+1] on the work register.
   assign fw0 = work_q[BLOCK_LENGTH-1            -: WORD_W];
   assign fw1 = work_q[BLOCK_LENGTH-1 -   WORD_W -: WORD_W];
   assign fw2 = work_q[BLOCK_LENGTH-1 - 2*WORD_W -: WORD_W];
   assign fw3 = work_q[BLOCK_LENGTH-1 - 3*WORD_W -: WORD_W];

   g_function uFwdG (
      .word_3             (fw3),
      .round_number       (rcnt_q),
      .word_3_substituted (fwdG)
   );

   assign fn0    = fw0 ^ fwdG;
   assign fn1    = fw1 ^ fn0;
   assign fn2    = fw2 ^ fn1;
   assign fn3    = fw3 ^ fn2;
   assign fwdKey = {fn0, fn1, fn2, fn3};

   // Inverse step K[i] -> K[i-1]; its own g copy keeps each path one S-box deep.
   assign cw0 = current_key_q[BLOCK_LENGTH-1            -: WORD_W];
   assign cw1 = current_key_q[BLOCK_LENGTH-1 -   WORD_W -: WORD_W];
   assign cw2 = current_key_q[BLOCK_LENGTH-1 - 2*WORD_W -: WORD_W];
   assign cw3 = current_key_q[BLOCK_LENGTH-1 - 3*WORD_W -: WORD_W];

   assign iw3 = cw3 ^ cw2;
   assign iw2 = cw2 ^ cw1;
   assign iw1 = cw1 ^ cw0;

   g_function uInvG (
      .word_3             (iw3),
      .round_number       (round_idx_q),
      .word_3_substituted (invG)
   );

   assign iw0    = cw0 ^ invG;
   assign invKey = {iw0, iw1, iw2, iw3};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Input priority in READY is start, then rewind, then en.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (kif.start) begin
               state_d = ST_EXPAND;
            end else if (kif.rewind && cache_valid_q) begin
               state_d = ST_READY;
            end
         end
         ST_EXPAND: begin
            if (rcnt_q == LAST_ROUND) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (kif.start) begin
               state_d = ST_EXPAND;
            end else if (!kif.rewind && kif.en && (round_idx_q == 4'd0)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      work_d        = work_q;
      k10_cache_d   = k10_cache_q;
      current_key_d = current_key_q;
      rcnt_d        = rcnt_q;
      round_idx_d   = round_idx_q;
      cache_valid_d = cache_valid_q;
      key_valid_d   = key_valid_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (kif.start) begin
               work_d = kif.key;
               rcnt_d = 4'd1;
               busy_d = 1'b1;
            end else if (kif.rewind && cache_valid_q) begin
               current_key_d = k10_cache_q;
               round_idx_d   = LAST_ROUND;
               key_valid_d   = 1'b1;
            end
         end
         ST_EXPAND: begin
            work_d = fwdKey;
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == LAST_ROUND) begin
               current_key_d = fwdKey;
               k10_cache_d   = fwdKey;
               round_idx_d   = LAST_ROUND;
               key_valid_d   = 1'b1;
               busy_d        = 1'b0;
               cache_valid_d = 1'b1;
            end
         end
         ST_READY: begin
            if (kif.start) begin
               work_d      = kif.key;
               rcnt_d      = 4'd1;
               busy_d      = 1'b1;
               key_valid_d = 1'b0;
            end else if (kif.rewind) begin
               current_key_d = k10_cache_q;
               round_idx_d   = LAST_ROUND;
            end else if (kif.en) begin
               if (round_idx_q != 4'd0) begin
                  current_key_d = invKey;
                  round_idx_d   = round_idx_q - 4'd1;
               end else begin
                  key_valid_d = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
         default: begin
            busy_d      = 1'b0;
            key_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         work_q        <= '0;
         k10_cache_q   <= '0;
         current_key_q <= '0;
         rcnt_q        <= '0;
         round_idx_q   <= '0;
         cache_valid_q <= 1'b0;
         key_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         work_q        <= work_d;
         k10_cache_q   <= k10_cache_d;
         current_key_q <= current_key_d;
         rcnt_q        <= rcnt_d;
         round_idx_q   <= round_idx_d;
         cache_valid_q <= cache_valid_d;
         key_valid_q   <= key_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign kif.current_key = current_key_q;
   assign kif.round_idx   = round_idx_q;
   assign kif.key_valid   = key_valid_q;
   assign kif.busy        = busy_q;
   assign kif.done        = done_q;

endmodule

// File: tb/tb_key_generator_dec.sv
// Directed and random checks of the reverse AES-128 key schedule against an
// independent key-expansion model and FIPS-197 reference values.
module tb_key_generator_dec;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;
   int   expIdx     = 0;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic         valid;
      logic         done;
   } exp_t;

   exp_t         sbq[$];
   logic [127:0] rkModel [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   localparam logic [2047:0] SBOX_TB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   key_generator_dec_if #(.BLOCK_LENGTH(128)) kif ();

   key_generator_dec #(.BLOCK_LENGTH(128)) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sbModel(input logic [7:0] b);
      int base;
      base = 2047 - 8 * int'(b);
      return SBOX_TB[base -: 8];
   endfunction

   function automatic logic [7:0] rconModel(input int r);
      logic [7:0] table_rc [0:10];
      table_rc = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      return table_rc[r];
   endfunction

   function automatic logic [31:0] gModel(input logic [31:0] w, input int r);
      logic [31:0] rot;
      rot = {w[23:0], w[31:24]};
      return {sbModel(rot[31:24]) ^ rconModel(r), sbModel(rot[23:16]),
              sbModel(rot[15:8]), sbModel(rot[7:0])};
   endfunction

   // Plain FIPS-197 forward expansion; the bench only ever walks it backwards
   // by indexing, never by an inverse step.
   task automatic computeSchedule(input logic [127:0] k);
      logic [127:0] w;
      logic [31:0]  n0, n1, n2, n3;
      rkModel[0] = k;
      for (int r = 1; r <= 10; r++) begin
         w  = rkModel[r-1];
         n0 = w[127:96] ^ gModel(w[31:0], r);
         n1 = w[95:64] ^ n0;
         n2 = w[63:32] ^ n1;
         n3 = w[31:0] ^ n2;
         rkModel[r] = {n0, n1, n2, n3};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [127:0] k,
                                input logic e, input logic rw);
      kif.start  = s;
      kif.key    = k;
      kif.en     = e;
      kif.rewind = rw;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkScoreboard(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s: observed=empty-scoreboard expected=entry", tag);
      end else begin
         e = sbq.pop_front();
         checkOutput({tag, " key"}, kif.current_key, e.key);
         checkOutput({tag, " idx"}, 128'(kif.round_idx), 128'(e.idx));
         checkOutput({tag, " valid"}, 128'(kif.key_valid), 128'(e.valid));
         checkOutput({tag, " done"}, 128'(kif.done), 128'(e.done));
      end
   endtask

   // One en per cycle, back to back; the final one past K0 expects done.
   task automatic enSteps(input int n, input string tag);
      exp_t e;
      for (int j = 0; j < n; j++) begin
         if (expIdx > 0) begin
            e = '{rkModel[expIdx-1], 4'(expIdx - 1), 1'b1, 1'b0};
            expIdx--;
         end else begin
            e = '{rkModel[0], 4'd0, 1'b0, 1'b1};
         end
         sbq.push_back(e);
         applyStimulus(1'b0, kif.key, 1'b1, 1'b0);
         tick();
         checkScoreboard(tag);
      end
      applyStimulus(1'b0, kif.key, 1'b0, 1'b0);
   endtask

   task automatic expandAndCheck(input logic [127:0] k, input logic noise,
                                 input string tag);
      int cycles;
      int busyCycles;
      computeSchedule(k);
      applyStimulus(1'b1, k, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, k, noise, noise);
      checkOutput({tag, " busy after start"}, 128'(kif.busy), 128'(1));
      checkOutput({tag, " valid after start"}, 128'(kif.key_valid), 128'(0));
      cycles     = 0;
      busyCycles = 1;
      while (!kif.key_valid && cycles < 20) begin
         tick();
         cycles++;
         if (kif.busy) busyCycles++;
      end
      applyStimulus(1'b0, k, 1'b0, 1'b0);
      checkOutput({tag, " latency"}, 128'(cycles), 128'(10));
      checkOutput({tag, " busy cycles"}, 128'(busyCycles), 128'(10));
      checkOutput({tag, " busy at K10"}, 128'(kif.busy), 128'(0));
      checkOutput({tag, " idx at K10"}, 128'(kif.round_idx), 128'(10));
      checkOutput({tag, " K10"}, kif.current_key, rkModel[10]);
      expIdx = 10;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " current_key"}, kif.current_key, 128'(0));
      checkOutput({tag, " round_idx"}, 128'(kif.round_idx), 128'(0));
      checkOutput({tag, " key_valid"}, 128'(kif.key_valid), 128'(0));
      checkOutput({tag, " busy"}, 128'(kif.busy), 128'(0));
      checkOutput({tag, " done"}, 128'(kif.done), 128'(0));
   endtask

   initial begin
      logic [127:0] rkey;
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #3 rst = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b1;
      tick();

      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("rewind w/o cache valid", 128'(kif.key_valid), 128'(0));
      checkOutput("rewind w/o cache idx", 128'(kif.round_idx), 128'(0));

      $display("[TB] FIPS-197 key expansion and reverse delivery");
      expandAndCheck(FIPS_KEY, 1'b0, "fips");
      checkOutput("fips K10 reference", kif.current_key, FIPS_K10);
      enSteps(1, "fips step");
      checkOutput("fips K9 reference", kif.current_key, FIPS_K9);
      enSteps(8, "fips step");
      checkOutput("fips K1 reference", kif.current_key, FIPS_K1);
      checkOutput("fips idx at K1", 128'(kif.round_idx), 128'(1));
      enSteps(1, "fips step");
      checkOutput("fips K0 reference", kif.current_key, FIPS_KEY);
      enSteps(1, "fips done");
      tick();
      checkOutput("done is one cycle", 128'(kif.done), 128'(0));

      applyStimulus(1'b0, kif.key, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, kif.key, 1'b0, 1'b0);
      checkOutput("rewind from idle key", kif.current_key, FIPS_K10);
      checkOutput("rewind from idle idx", 128'(kif.round_idx), 128'(10));
      checkOutput("rewind from idle valid", 128'(kif.key_valid), 128'(1));
      checkOutput("rewind from idle busy", 128'(kif.busy), 128'(0));
      expIdx = 10;

      enSteps(1, "pre-collision");
      applyStimulus(1'b0, kif.key, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, kif.key, 1'b0, 1'b0);
      checkOutput("rewind beats en idx", 128'(kif.round_idx), 128'(10));
      checkOutput("rewind beats en key", kif.current_key, FIPS_K10);
      expIdx = 10;

      enSteps(5, "to idx5");
      checkOutput("idx before restart", 128'(kif.round_idx), 128'(5));
      $display("[TB] restart from READY with noise during expansion");
      expandAndCheck(SEQ_KEY, 1'b1, "restart");
      checkOutput("restart K10 reference", kif.current_key, SEQ_K10);

      enSteps(2, "pre-reset");
      #2 rst = 1'b0;
      #1 checkAllZero("async reset in READY");
      tick();
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("rewind after reset valid", 128'(kif.key_valid), 128'(0));
      checkOutput("rewind after reset key", kif.current_key, 128'(0));

      applyStimulus(1'b1, SEQ_KEY, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, SEQ_KEY, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("busy mid-expand", 128'(kif.busy), 128'(1));
      #2 rst = 1'b0;
      #1 checkAllZero("async reset in EXPAND");
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] random keys");
      for (int n = 0; n < 100; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         expandAndCheck(rkey, 1'b0, "random");
         enSteps(11, "random step");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/key_generator_dec.md
Name: key_generator_dec

Overview:
- AES-128 decryption key schedule: expands the cipher key forward to K10, then delivers round keys in reverse order (K10, K9, ... K0), one per advance request.
- Sits beside the decryption round datapath; the decryption FSM consumes current_key each round.
- Keeps a 128-bit K10 cache so consecutive blocks under the same key replay the schedule without re-expansion.

Parameters:
- BLOCK_LENGTH, 128, key/round-key width; only 128 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  latch key and begin forward expansion.
- key  input  BLOCK_LENGTH  cipher key K0, sampled when start is accepted.
- en  input  1  advance request: step current_key to the previous round key.
- rewind  input  1  reload the cached K10 without re-expansion.
- current_key  output  BLOCK_LENGTH  current round key K[round_idx].
- round_idx  output  4  index of current_key (10 down to 0).
- key_valid  output  1  current_key/round_idx valid.
- busy  output  1  forward expansion in progress.
- done  output  1  one-cycle pulse: K0 consumed.

Behaviour:
- Reset, asynchronous and active-low: all outputs 0, the work register and K10 cache 0, cache_valid 0, state IDLE. Reset mid-operation aborts immediately; there is no resume.
- Registers: work[127:0], k10_cache[127:0], rcnt[3:0], round_idx[3:0], cache_valid, state.
- States: IDLE, EXPAND, READY.
- IDLE, start=1: work<=key, rcnt<=1, busy<=1, go to EXPAND.
- IDLE, rewind=1 and cache_valid: current_key<=k10_cache, round_idx<=10, key_valid<=1, go to READY. Otherwise en/rewind are ignored.
- EXPAND: each cycle work<=fwd(work, rcon(rcnt)) and rcnt++.
  - On the cycle rcnt==10: also load current_key and k10_cache with fwd(...), set round_idx<=10, key_valid<=1, busy<=0, cache_valid<=1, go to READY.
  - Latency: start sampled at edge 0 gives key_valid high after edge 10, i.e. 10 cycles. start/en/rewind are ignored during EXPAND.
- fwd(w0..w3, rc): g=g_function(w3, rc); n0=w0^g; n1=w1^n0; n2=w2^n1; n3=w3^n2.
- inv(n0..n3, rc), recovering K[i-1] from K[i] with rc=rcon(i): w3=n3^n2; w2=n2^n1; w1=n1^n0; w0=n0^g_function(w3, rc).
- rcon: 1..8 gives 01,02,04,...,80; 9 gives 1B; 10 gives 36; otherwise 00.
- READY, en=1 and round_idx>0: current_key<=inv(current_key, rcon(round_idx)), round_idx--. One key per en, zero bubbles; back-to-back en is allowed.
- READY, en=1 and round_idx==0: key_valid<=0, done<=1 for one cycle, go to IDLE. cache_valid is retained.
- READY, rewind=1: current_key<=k10_cache, round_idx<=10; state unchanged.
- READY, start=1: abandon the delivery, key_valid<=0, begin a new EXPAND with the new key.
- Priority when inputs coincide: start > rewind > en.
- current_key holds its value while en=0. done is 0 in every other cycle.

Decomposition:
- Shared package aes_pkg: rcon lookup function, AES_ROUNDS=10, KEY_WORDS=4, state encoding.
- Sub-module: reuse the existing g_function (RotWord+SubWord+Rcon, ports word_3, round_number, word_3_substituted).
  - Instantiate two copies: one for fwd, one for inv. Do not mux a single copy, so the timing path stays one S-box deep per stage.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> busy for 10 cycles, then key_valid=1, round_idx=10, current_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Continuing, en=1 for 10 consecutive cycles:
  - After the first en: K9=ac7766f319fadc2128d12941575c006e.
  - Ninth en: round_idx=1, K1=a0fafe1788542cb123a339392a6c7605.
  - Tenth en: round_idx=0, key=K0.
  - Eleventh en: done pulse, key_valid=0.
- After done, rewind=1 -> next cycle round_idx=10 and the K10 value above, with no busy cycles. Also compare the full reverse sequence against a software model for 100 random keys.
- en and rewind asserted during EXPAND -> ignored, K10 still correct at cycle 10. rewind and en in the same cycle in READY -> rewind wins (round_idx=10).
- start asserted in READY at round_idx=5 with key 000102...0f -> key_valid drops, K10=13111d7fe3944a17f307a78b4d2b30c5 after 10 cycles.
- rst driven low asynchronously mid-EXPAND and mid-READY -> all outputs 0 immediately (before the next edge). rewind after reset is ignored because cache_valid=0.
